// File: rtl/sr_bank_driver.sv
// sr_bank_driver: issues timed, non-overlapping set/reset pulses to a bank of SR flops.
// Define SR_DRV_READBACK_EN to add a q_fb readback check (VERIFY state, err flag).
module sr_bank_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1,
    parameter int unsigned VERIFY_TO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] shadow
);

    // Count-down counters hold at most param-1, shared by every timed state.
    localparam int unsigned MaxPg  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned MaxCyc = (MaxPg > VERIFY_TO) ? MaxPg : VERIFY_TO;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StGap,
        StVerify,
        StDone
    } state_e;

`ifdef SR_DRV_READBACK_EN
    localparam logic [CntW-1:0] VerifyLoad = CntW'(VERIFY_TO - 1);
    localparam state_e PostGap = StVerify;
`else
    localparam state_e PostGap = StDone;
`endif
    localparam state_e PostDrive = (GAP_CYC == 0) ? PostGap : StGap;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              accept;
    logic              cnt_zero;

    assign accept   = req_valid & req_ready;
    assign cnt_zero = (cnt_q == '0);

`ifdef SR_DRV_READBACK_EN
    logic verify_ok;
    logic err_q, err_d;

    assign verify_ok = (((q_fb ^ target_q) & mask_q) == '0);
`else
    logic unused_q_fb;

    assign unused_q_fb = ^q_fb;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (req_mask == '0) ? StDone : StDrive;
                end
            end
            StDrive: begin
                if (cnt_zero) state_d = PostDrive;
            end
            StGap: begin
                if (cnt_zero) state_d = PostGap;
            end
`ifdef SR_DRV_READBACK_EN
            StVerify: begin
                if (verify_ok || cnt_zero) state_d = StDone;
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded outputs
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign busy   = ~req_ready;
    assign s      = s_q;
    assign r      = r_q;
    assign shadow = shadow_q;

    // Datapath next-state: command capture, pulse timing and shadow update
    always_comb begin
        target_d = accept ? req_target : target_q;
        mask_d   = accept ? req_mask : mask_q;

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                StDrive: cnt_d = PulseLoad;
                StGap:   cnt_d = GapLoad;
`ifdef SR_DRV_READBACK_EN
                StVerify: cnt_d = VerifyLoad;
`endif
                default: cnt_d = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
        end

        // s/r are registered: drive them for the cycles the FSM will spend in DRIVE.
        s_d = '0;
        r_d = '0;
        if (state_d == StDrive) begin
            s_d = mask_d & target_d;
            r_d = mask_d & ~target_d;
        end

        shadow_d = shadow_q;
        if (state_q == StDrive && cnt_zero) begin
            shadow_d = (shadow_q & ~mask_q) | (target_q & mask_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            target_q <= '0;
            mask_q   <= '0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            target_q <= target_d;
            mask_q   <= mask_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef SR_DRV_READBACK_EN
    // err rises together with done on a timeout and holds until the next accept.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (state_q == StVerify && !verify_ok && cnt_zero) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
